histogram_peak_scan: RTL and testbench
======================================

Name: histogram_peak_scan

Overview:
- Downstream consumer of the data_statistics histogram block.
- Once a collection window has closed (finish done), this block sweeps the histogram read port. It drives get_summary/index and captures summary after the fixed read latency.
- Reduces the bins to peak bin, peak count, total count and number of occupied bins, then reports them with a single-cycle done pulse for the next stage.

Parameters:
- DSIZE, 10, width of bin index (matches data_statistics DSIZE).
- SSIZE, 32, width of per-bin summary count.
- RANGE, 20, number of bins scanned (indices 0..RANGE-1); legal range 1..2**DSIZE.
- LAT, 2, clock cycles from index presented to corresponding summary valid; legal range 1..8.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a scan when block idle.
- get_summary  out  1  read enable to data_statistics.
- index  out  DSIZE  bin address to data_statistics.
- summary  in  SSIZE  bin count returned LAT cycles after index.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid and held from this cycle.
- peak_index  out  DSIZE  lowest index holding the maximum count.
- peak_value  out  SSIZE  maximum bin count.
- total  out  SSIZE+DSIZE  sum of all scanned bins; no overflow possible at this width.
- nonzero_bins  out  DSIZE+1  number of bins with count > 0.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; get_summary, busy, done=0; index=0; all result outputs=0; tag pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN, REPORT.
- IDLE:
  - start=1 at an edge -> ISSUE.
  - Same edge: get_summary<=1, index<=0, busy<=1, internal accumulators cleared.
  - Result outputs keep their previous values until REPORT.
- ISSUE:
  - index increments by 1 each cycle.
  - A valid tag carrying the index enters a LAT-deep shift pipeline each cycle.
  - When index==RANGE-1 is issued -> DRAIN; index then holds RANGE-1.
- DRAIN:
  - get_summary stays 1 (data_statistics requires it held across the read window).
  - Remains here until the last tag exits the pipeline.
  - Then get_summary<=0 -> REPORT.
- Capture, on each edge where the pipeline output tag is valid:
  - total += summary.
  - nonzero += (summary!=0).
  - If summary > running max (strict), max<=summary and max_idx<=tag index. Ties keep the lower index.
  - Running max is initialised to 0 and max_idx to 0, so an all-zero histogram reports peak_index=0, peak_value=0.
- REPORT:
  - Register accumulators onto result outputs; done=1 for exactly one cycle; busy<=0 -> IDLE.
- Timing: start sampled at edge E0; index k is presented in the cycle after edge E0+k. done is high in the cycle after edge E0+RANGE+LAT+1. Total scan = RANGE+LAT+2 cycles, start to IDLE.
- start while busy: ignored, no restart, no queuing. start in the REPORT cycle is also ignored.
- RANGE=1: ISSUE lasts one cycle; the DRAIN path is unchanged.
- rst_n low mid-scan: immediate return to reset values; partial results discarded; no done.
- summary is ignored whenever no valid tag is present.

Optional Feature:
- Macro: HIST_THRESH_EN.
- Defined:
  - Adds input thresh (SSIZE) and output above_bins (DSIZE+1).
  - thresh is sampled at start acceptance and held for the scan.
  - above_bins counts captured bins with summary >= thresh; it updates with the other results at done, and resets to 0.
- Not defined: both ports absent; no threshold logic is synthesised.

Test Plan:
- All-zero histogram, RANGE=20, LAT=2, start pulse:
  - get_summary high 21 cycles (20 ISSUE + 1 DRAIN); done at cycle E0+23.
  - peak_index=0, peak_value=0, total=0, nonzero_bins=0.
- Model with bin7=55, others 3:
  - peak_index=7, peak_value=55, total=112, nonzero_bins=20.
- Tie, bins 4 and 12 both 40, others 0:
  - peak_index=4, peak_value=40, total=80, nonzero_bins=2.
- start re-pulsed at cycles E0+5 and in the REPORT cycle:
  - Exactly one done; results unchanged from a single scan; next start accepted in IDLE.
- rst_n pulled low at E0+10:
  - All outputs 0 asynchronously; no done.
  - A fresh scan afterwards gives correct results.
- Build with HIST_THRESH_EN, thresh=10, bins {0:12, 1:10, 2:9}, rest 0:
  - above_bins=2.
  - Repeat with LAT=4 model: done moves to E0+RANGE+5, same results.

Source files
------------

// File: rtl/histogram_peak_scan.sv
// rtl/histogram_peak_scan.sv - sweeps a histogram read port, reports peak bin, total and occupancy
// Optional macro HIST_THRESH_EN adds thresh input and above_bins count.
module histogram_peak_scan #(
  parameter int DSIZE = 10,
  parameter int SSIZE = 32,
  parameter int RANGE = 20,
  parameter int LAT   = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   get_summary,
  output logic [DSIZE-1:0]       index,
  input  logic [SSIZE-1:0]       summary,
  output logic                   busy,
  output logic                   done,
  output logic [DSIZE-1:0]       peak_index,
  output logic [SSIZE-1:0]       peak_value,
  output logic [SSIZE+DSIZE-1:0] total,
  output logic [DSIZE:0]         nonzero_bins
`ifdef HIST_THRESH_EN
  ,
  input  logic [SSIZE-1:0]       thresh,
  output logic [DSIZE:0]         above_bins
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;
  localparam logic [DSIZE-1:0] LAST = DSIZE'(RANGE - 1);

  state_t                 state, state_next;
  logic [LAT-1:0]         tag_valid;
  logic [DSIZE-1:0]       tag_idx [LAT];
  logic                   cap_valid, cap_last, accept, pend;
  logic                   get_summary_next, busy_next, done_next;
  logic [DSIZE-1:0]       index_next;
  logic [DSIZE-1:0]       max_idx;
  logic [SSIZE-1:0]       max_val;
  logic [SSIZE+DSIZE-1:0] total_acc;
  logic [DSIZE:0]         nz_acc;

  assign cap_valid = tag_valid[LAT-1];
  assign cap_last  = cap_valid && (tag_idx[LAT-1] == LAST);
  assign accept    = (state == IDLE) && start;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (index == LAST) state_next = DRAIN;
      DRAIN:   if (cap_last) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read enable drops once the last tag will sit in the output stage next cycle;
  // its summary is already in flight inside data_statistics by then.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < LAT - 2; i++) pend = pend | tag_valid[i];
    get_summary_next = get_summary;
    busy_next        = busy;
    done_next        = 1'b0;
    index_next       = index;
    case (state)
      IDLE: if (start) begin
        get_summary_next = 1'b1;
        busy_next        = 1'b1;
        index_next       = '0;
      end
      ISSUE:   if (index != LAST) index_next = index + 1'b1;
      DRAIN:   if (!pend) get_summary_next = 1'b0;
      REPORT: begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      get_summary  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      index        <= '0;
      tag_valid    <= '0;
      for (int i = 0; i < LAT; i++) tag_idx[i] <= '0;
      max_idx      <= '0;
      max_val      <= '0;
      total_acc    <= '0;
      nz_acc       <= '0;
      peak_index   <= '0;
      peak_value   <= '0;
      total        <= '0;
      nonzero_bins <= '0;
    end else begin
      get_summary <= get_summary_next;
      busy        <= busy_next;
      done        <= done_next;
      index       <= index_next;
      tag_valid[0] <= (state == ISSUE);
      tag_idx[0]   <= index;
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
      if (accept) begin
        max_idx   <= '0;
        max_val   <= '0;
        total_acc <= '0;
        nz_acc    <= '0;
      end else if (cap_valid) begin
        total_acc <= total_acc + {{DSIZE{1'b0}}, summary};
        nz_acc    <= nz_acc + {{DSIZE{1'b0}}, |summary};
        if (summary > max_val) begin
          max_val <= summary;
          max_idx <= tag_idx[LAT-1];
        end
      end
      if (state == REPORT) begin
        peak_index   <= max_idx;
        peak_value   <= max_val;
        total        <= total_acc;
        nonzero_bins <= nz_acc;
      end
    end
  end

`ifdef HIST_THRESH_EN
  logic [SSIZE-1:0] thresh_q;
  logic [DSIZE:0]   above_acc;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q   <= '0;
      above_acc  <= '0;
      above_bins <= '0;
    end else begin
      if (accept) begin
        thresh_q  <= thresh;
        above_acc <= '0;
      end else if (cap_valid) begin
        above_acc <= above_acc + {{DSIZE{1'b0}}, (summary >= thresh_q)};
      end
      if (state == REPORT) above_bins <= above_acc;
    end
  end
`endif

endmodule

// File: tb/tb_histogram_peak_scan.sv
// tb/tb_histogram_peak_scan.sv - directed bench for histogram_peak_scan at LAT=2 and LAT=4
module tb_histogram_peak_scan;
  localparam int DS = 10;
  localparam int SS = 32;
  localparam int R  = 20;

  typedef struct {longint pi; longint pv; longint tot; longint nz; longint ab;} res_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [SS-1:0] thresh_v = 32'd10;
  always #5 clock = ~clock;

  int unsigned hist [1024];
  int edges = 0, e0 = 0, checks = 0, failures = 0;
  int dcnt_a = 0, dcnt_b = 0, gs_a = 0;
  res_t exp_next = '{0, 0, 0, 0, 0};
  res_t hold_a = '{0, 0, 0, 0, 0};
  res_t hold_b = '{0, 0, 0, 0, 0};

  logic gsum_a, busy_a, done_a, gsum_b, busy_b, done_b;
  logic [DS-1:0] idx_a, pi_a, idx_b, pi_b;
  logic [SS-1:0] sum_a, pv_a, sum_b, pv_b;
  logic [SS+DS-1:0] tot_a, tot_b;
  logic [DS:0] nz_a, nz_b;
`ifdef HIST_THRESH_EN
  logic [DS:0] ab_a, ab_b;
`endif

  histogram_peak_scan #(.DSIZE(DS), .SSIZE(SS), .RANGE(R), .LAT(2)) dut_a (
    .clock(clock), .rst_n(rst_n), .start(start), .get_summary(gsum_a), .index(idx_a),
    .summary(sum_a), .busy(busy_a), .done(done_a), .peak_index(pi_a), .peak_value(pv_a),
    .total(tot_a), .nonzero_bins(nz_a)
`ifdef HIST_THRESH_EN
    , .thresh(thresh_v), .above_bins(ab_a)
`endif
  );

  histogram_peak_scan #(.DSIZE(DS), .SSIZE(SS), .RANGE(R), .LAT(4)) dut_b (
    .clock(clock), .rst_n(rst_n), .start(start), .get_summary(gsum_b), .index(idx_b),
    .summary(sum_b), .busy(busy_b), .done(done_b), .peak_index(pi_b), .peak_value(pv_b),
    .total(tot_b), .nonzero_bins(nz_b)
`ifdef HIST_THRESH_EN
    , .thresh(thresh_v), .above_bins(ab_b)
`endif
  );

  // Histogram memory models: summary returns LAT cycles after index, junk otherwise.
  logic [DS-1:0] pa [2] = '{default: '0};
  logic          qa [2] = '{default: 1'b0};
  logic [DS-1:0] pb [4] = '{default: '0};
  logic          qb [4] = '{default: 1'b0};
  always @(posedge clock) begin
    edges <= edges + 1;
    pa[0] <= idx_a; qa[0] <= gsum_a;
    pa[1] <= pa[0]; qa[1] <= qa[0];
    pb[0] <= idx_b; qb[0] <= gsum_b;
    for (int i = 1; i < 4; i++) begin
      pb[i] <= pb[i-1];
      qb[i] <= qb[i-1];
    end
  end
  assign sum_a = qa[1] ? hist[pa[1]] : 32'hDEAD_BEEF;
  assign sum_b = qb[3] ? hist[pb[3]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input longint th);
    res_t r = '{0, 0, 0, 0, 0};
    for (int i = 0; i < R; i++) begin
      r.tot += hist[i];
      if (hist[i] != 0) r.nz++;
      if (hist[i] >= th) r.ab++;
      if (hist[i] > r.pv) r.pv = hist[i];
    end
    for (int i = R - 1; i >= 0; i--) if (hist[i] == r.pv) r.pi = i;
    return r;
  endfunction

  task automatic chk_res(input string n, input res_t h, input longint pi, input longint pv,
                         input longint tot, input longint nz);
    chk({n, "_peak_index"}, pi, h.pi);
    chk({n, "_peak_value"}, pv, h.pv);
    chk({n, "_total"}, tot, h.tot);
    chk({n, "_nonzero"}, nz, h.nz);
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      if (done_a) begin
        dcnt_a++;
        chk("done_time_a", edges - e0, R + 3);
        chk("gs_cycles_a", gs_a, R + 1);
        hold_a = exp_next;
      end
      if (done_b) begin
        dcnt_b++;
        chk("done_time_b", edges - e0, R + 5);
        hold_b = exp_next;
      end
      chk_res("a", hold_a, pi_a, pv_a, tot_a, nz_a);
      chk_res("b", hold_b, pi_b, pv_b, tot_b, nz_b);
`ifdef HIST_THRESH_EN
      chk("above_a", ab_a, hold_a.ab);
      chk("above_b", ab_b, hold_b.ab);
`endif
      if (gsum_a) begin
        gs_a++;
        if (edges - e0 < R) chk("index_a", idx_a, edges - e0);
      end
      if (gsum_b && edges - e0 < R) chk("index_b", idx_b, edges - e0);
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    e0 = edges + 1;
    gs_a = 0;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic scan(input string n, input bit extra, input longint xpi, input longint xpv,
                      input longint xtot, input longint xnz, input longint xab);
    int ba, bb;
    ba = dcnt_a;
    bb = dcnt_b;
    exp_next = model(thresh_v);
    chk({n, "_model_pi"}, exp_next.pi, xpi);
    chk({n, "_model_tot"}, exp_next.tot, xtot);
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (extra) start = (edges - e0 == 4) || (edges - e0 == 22);
    end
    start = 1'b0;
    chk({n, "_done_count_a"}, dcnt_a - ba, 1);
    chk({n, "_done_count_b"}, dcnt_b - bb, 1);
    chk({n, "_idle_a"}, busy_a, 0);
    chk({n, "_idle_b"}, busy_b, 0);
    chk({n, "_lit_pi"}, pi_a, xpi);
    chk({n, "_lit_pv"}, pv_a, xpv);
    chk({n, "_lit_tot"}, tot_b, xtot);
    chk({n, "_lit_nz"}, nz_b, xnz);
`ifdef HIST_THRESH_EN
    chk({n, "_lit_above"}, ab_a, xab);
`else
    chk({n, "_model_above"}, exp_next.ab, xab);
`endif
  endtask

  task automatic set_hist(input int fill);
    for (int i = 0; i < 1024; i++) hist[i] = fill;
  endtask

  initial begin
    int ba, bb;
    set_hist(0);
    #12;
    chk("rst_gsum", gsum_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_b, 0);
    chk("rst_index", idx_a, 0);
    chk("rst_total", tot_a, 0);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    scan("zero", 1'b0, 0, 0, 0, 0, 0);

    set_hist(3);
    hist[7] = 55;
    scan("peak7", 1'b0, 7, 55, 112, 20, 1);

    set_hist(0);
    hist[4] = 40;
    hist[12] = 40;
    scan("tie", 1'b0, 4, 40, 80, 2, 2);
    scan("restart", 1'b1, 4, 40, 80, 2, 2);

    set_hist(3);
    hist[7] = 55;
    ba = dcnt_a;
    bb = dcnt_b;
    exp_next = model(thresh_v);
    pulse_start();
    repeat (10) @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gsum", gsum_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_index", idx_b, 0);
    chk("arst_peak", pv_a, 0);
    chk("arst_total", tot_b, 0);
    chk("arst_nz", nz_a, 0);
    hold_a = '{0, 0, 0, 0, 0};
    hold_b = '{0, 0, 0, 0, 0};
    @(negedge clock);
    rst_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("arst_no_done_a", dcnt_a - ba, 0);
    chk("arst_no_done_b", dcnt_b - bb, 0);

    set_hist(0);
    hist[0] = 12;
    hist[1] = 10;
    hist[2] = 9;
    scan("thresh", 1'b0, 0, 12, 31, 3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
